huff_packer: RTL and testbench
==============================

# huff_packer

Downstream stage of `huffman`: captures the six-entry Huffman code table (HC1..HC6 / M1..M6) when `code_valid` pulses. It then encodes a stream of gray symbols (values 1..6) into an MSB-first packed byte stream using a valid/ready output handshake. A flush request pads the final partial byte with zeros and marks it with `out_last`.

## Interface
- Parameters:
- `NSYM`, 6: number of symbols; fixed by the code table.
- `MAXLEN`, 7: maximum legal code length in bits.
- Ports:
- `clk`  in  1  single clock, all logic on rising edge.
- `reset`  in  1  synchronous, active-low; `reset`=0 at a rising edge clears the block.
- `code_valid`  in  1  table-load strobe from `huffman`.
- `HC1`..`HC6`  in  8 each  code bits, right-aligned.
- `M1`..`M6`  in  8 each  mask, contiguous ones in the LSBs; code length = popcount.
- `sym_valid`  in  1  symbol present.
- `sym_data`  in  8  gray symbol; legal values 1..6.
- `sym_ready`  out  1  symbol accepted when `sym_valid`&`sym_ready`.
- `flush`  in  1  one-cycle request to terminate the stream.
- `out_valid`  out  1  packed byte present.
- `out_data`  out  8  packed byte, first code bit in bit 7.
- `out_last`  out  1  qualifies the final byte of the stream.
- `out_ready`  in  1  downstream accepts when `out_valid`&`out_ready`.
- `sym_err`  out  1  one-cycle pulse when an illegal symbol is accepted.

## Operation
- States: IDLE, RUN, FLUSH.
  - IDLE: `code_valid`=1 loads the table (HCi & Mi, len_i = popcount(Mi), 3 bits) and moves to RUN.
  - RUN: `code_valid` is ignored in RUN and FLUSH.
  - A `flush` pulse in RUN sets `flush_pend`, and `sym_ready` drops the next cycle. The state moves to FLUSH once no symbol is being accepted that cycle. `flush` in IDLE is ignored.
  - FLUSH: emits remaining full bytes, then one zero-padded byte with `out_last`=1. If 0 bits remain, it emits nothing and `out_last` is never asserted. It then returns to IDLE, so a new table load is required.
- Bit buffer: `buf[15:0]` MSB-aligned with `cnt[4:0]` (0..15).
  - `sym_ready` = RUN & !`flush_pend` & `cnt`<8. This guarantees `cnt`+len ≤ 7+7 = 14 with no overflow.
  - `out_valid` = (RUN & `cnt`≥8) | (FLUSH & `cnt`>0).
  - `out_data` = `buf[15:8]`. In FLUSH with `cnt`<8, the bits below `cnt` are already zero.
- Per cycle:
  - First, if the output fires, shift the buffer left 8 and set `cnt` -= 8, saturating at 0 for the last byte.
  - Then, if a symbol is accepted, OR its code into the buffer starting at bit (15 − post-shift `cnt`), and add len to `cnt`.
  - Both can occur in the same cycle.
- Illegal symbol (0 or >6):
  - The symbol is consumed.
  - No bits are appended.
  - `sym_err`=1 for the next cycle.
- Unused buffer bits are always held at zero.

## Timing
- Reset values:
  - `sym_ready`, `out_valid`, `out_last`, `sym_err` = 0.
  - `out_data` = 0.
  - `buf`, `cnt`, `flush_pend`, and all table entries = 0.
  - State = IDLE.
- Reset mid-operation discards all buffered bits immediately; no byte is emitted.
- Table load at cycle N: RUN and `sym_ready` are active at N+1.
- Symbol accepted at N: bits are in `buf` at N+1. If `cnt` reaches ≥8, `out_valid` is high at N+1.
- `out_valid`/`out_data`/`out_last` hold stable while `out_ready`=0.
- Throughput: one byte per cycle sustained when codes average ≥8 bits per accepted symbol. Otherwise throughput is limited to one symbol per cycle.

## Structure
- Package `huff_pkg`:
  - `NSYM`, `MAXLEN`.
  - State enum {IDLE, RUN, FLUSH}.
  - Code-table entry struct {code[7:0], len[2:0]}.
- Sub-module `huff_code_table`: holds 6 registered entries, computes popcount at load, and provides a combinational lookup by symbol with an illegal flag.
- Packer FSM and buffer live in the top module.

## Test plan
All tests use this table:

| Symbol | Bits | HC/M |
|---|---|---|
| 1 | "0" | 0x00/0x01 |
| 2 | "10" | 0x02/0x03 |
| 3 | "110" | 0x06/0x07 |
| 4 | "1110" | 0x0E/0x0F |
| 5 | "11110" | 0x1E/0x1F |
| 6 | "11111" | 0x1F/0x1F |

- Load, send symbols 1,2,3,4, then `flush` with `out_ready`=1 → bytes 0x5B then 0x80 with `out_last`=1; back to IDLE.
- Eight × symbol 1, then `flush` → single byte 0x00 with `out_last`=0; no padded byte.
- Symbols 6,6,6,6 with `out_ready`=0 for 10 cycles:
  - `sym_ready` falls after the second symbol (`cnt`=10); `out_data`=0xFF is held stable.
  - On release → 0xFF, 0xFF, then `flush` → 0xF0 with `out_last`=1.
- Symbol 0 and symbol 7 injected between symbols 2,2 → `sym_err` pulses twice; stream is identical to 2,2 alone (flush → 0xA0 last).
- `code_valid` pulsed during RUN with a different table → ignored; encoding continues with the original codes.
- `reset`=0 while `cnt`=5 and `out_valid`=0 → next cycle all outputs 0 and state IDLE; subsequent `sym_valid` is not accepted until a table load.

Source files
------------

// File: rtl/huff_pkg.sv
// rtl/huff_pkg.sv - shared constants, state encoding and code-table entry type for huff_packer
package huff_pkg;

  localparam int NSYM   = 6;
  localparam int MAXLEN = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  typedef struct packed {
    logic [7:0] code;
    logic [2:0] len;
  } code_entry_t;

  // Number of set bits in a byte; the code length is the popcount of its mask.
  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/huff_code_table.sv
// rtl/huff_code_table.sv - registered six-entry Huffman code table with symbol lookup
//
// Ports:
//   clk, reset      clock and synchronous active-low reset
//   load            capture hc_flat/m_flat into the table
//   hc_flat, m_flat packed code bits / masks, entry i in bits [8*i +: 8] (symbol i+1)
//   sym             symbol to look up (legal 1..NSYM)
//   code, len       right-aligned code and its length for sym
//   illegal         sym is 0 or above NSYM
module huff_code_table
  import huff_pkg::*;
#(
  parameter int NSYM   = 6,
  parameter int MAXLEN = 7
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic [8*NSYM-1:0]   hc_flat,
  input  logic [8*NSYM-1:0]   m_flat,
  input  logic [7:0]          sym,
  output logic [7:0]          code,
  output logic [2:0]          len,
  output logic                illegal
);

  // Bits above the longest legal code never reach the packer buffer.
  localparam logic [7:0] LEN_MASK = 8'((1 << MAXLEN) - 1);

  code_entry_t tbl [NSYM];
  logic [3:0]  pc  [NSYM];

  always_comb begin
    for (int i = 0; i < NSYM; i++) begin
      pc[i] = popcount8(m_flat[8*i +: 8]);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NSYM; i++) begin
        tbl[i] <= '0;
      end
    end else if (load) begin
      for (int i = 0; i < NSYM; i++) begin
        tbl[i].code <= hc_flat[8*i +: 8] & m_flat[8*i +: 8] & LEN_MASK;
        tbl[i].len  <= pc[i][2:0];
      end
    end
  end

  always_comb begin
    illegal = (sym == 8'd0) || (sym > 8'(NSYM));
    code    = '0;
    len     = '0;
    for (int i = 0; i < NSYM; i++) begin
      if (sym == 8'(i + 1)) begin
        code = tbl[i].code;
        len  = tbl[i].len;
      end
    end
  end

endmodule

// File: rtl/huff_packer.sv
// rtl/huff_packer.sv - packs Huffman-coded gray symbols into an MSB-first byte stream
//
// Ports:
//   clk, reset              clock and synchronous active-low reset
//   code_valid, HC1..HC6,   code table load (accepted only in IDLE)
//   M1..M6
//   sym_valid, sym_data,    symbol input handshake
//   sym_ready
//   flush                   terminate the stream (honoured in RUN)
//   out_valid, out_data,    packed byte output handshake, first code bit in bit 7
//   out_last, out_ready
//   sym_err                 pulses the cycle after an illegal symbol is consumed
module huff_packer
  import huff_pkg::*;
#(
  parameter int NSYM   = 6,
  parameter int MAXLEN = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       code_valid,
  input  logic [7:0] HC1,
  input  logic [7:0] HC2,
  input  logic [7:0] HC3,
  input  logic [7:0] HC4,
  input  logic [7:0] HC5,
  input  logic [7:0] HC6,
  input  logic [7:0] M1,
  input  logic [7:0] M2,
  input  logic [7:0] M3,
  input  logic [7:0] M4,
  input  logic [7:0] M5,
  input  logic [7:0] M6,
  input  logic       sym_valid,
  input  logic [7:0] sym_data,
  output logic       sym_ready,
  input  logic       flush,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       out_last,
  input  logic       out_ready,
  output logic       sym_err
);

  state_t      state;
  logic [15:0] bit_buf;
  logic [4:0]  cnt;
  logic        flush_pend;

  logic        tbl_load;
  logic [7:0]  lk_code;
  logic [2:0]  lk_len;
  logic        lk_illegal;

  logic        accept;
  logic        fire;
  logic [15:0] buf_shift;
  logic [4:0]  cnt_shift;
  logic [4:0]  sh;
  logic [15:0] app;
  logic [15:0] buf_next;
  logic [4:0]  cnt_next;

  assign tbl_load = (state == IDLE) && code_valid;

  huff_code_table #(
    .NSYM   (NSYM),
    .MAXLEN (MAXLEN)
  ) u_table (
    .clk     (clk),
    .reset   (reset),
    .load    (tbl_load),
    .hc_flat ({HC6, HC5, HC4, HC3, HC2, HC1}),
    .m_flat  ({M6, M5, M4, M3, M2, M1}),
    .sym     (sym_data),
    .code    (lk_code),
    .len     (lk_len),
    .illegal (lk_illegal)
  );

  // Handshake outputs are pure decodes of registered state, so they change
  // only on clock edges and hold while out_ready is low.
  always_comb begin
    sym_ready = (state == RUN) && !flush_pend && (cnt < 5'd8);
    out_valid = ((state == RUN) && (cnt >= 5'd8)) ||
                ((state == FLUSH) && (cnt != 5'd0));
    out_data  = bit_buf[15:8];
    // The last byte in FLUSH is the one that leaves no bits behind.
    out_last  = (state == FLUSH) && (cnt != 5'd0) && (cnt <= 5'd8);
  end

  assign accept = sym_valid && sym_ready;
  assign fire   = out_valid && out_ready;

  // Drain first, then append at the post-shift fill level. sym_ready requires
  // cnt < 8 so the appended code always fits in the 16-bit window.
  always_comb begin
    buf_shift = fire ? {bit_buf[7:0], 8'h00} : bit_buf;
    cnt_shift = fire ? ((cnt >= 5'd8) ? (cnt - 5'd8) : 5'd0) : cnt;
    sh        = 5'd16 - cnt_shift - {2'b00, lk_len};
    app       = {8'h00, lk_code} << sh;
    buf_next  = buf_shift;
    cnt_next  = cnt_shift;
    if (accept && !lk_illegal) begin
      buf_next = buf_shift | app;
      cnt_next = cnt_shift + {2'b00, lk_len};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      bit_buf    <= '0;
      cnt        <= '0;
      flush_pend <= 1'b0;
      sym_err    <= 1'b0;
    end else begin
      bit_buf <= buf_next;
      cnt     <= cnt_next;
      sym_err <= accept && lk_illegal;
      case (state)
        IDLE: begin
          flush_pend <= 1'b0;
          if (code_valid) begin
            state <= RUN;
          end
        end
        RUN: begin
          // A symbol accepted in the same cycle as flush must still land
          // before the stream is closed.
          if (flush_pend && !accept) begin
            state      <= FLUSH;
            flush_pend <= 1'b0;
          end else if (flush) begin
            flush_pend <= 1'b1;
          end
        end
        FLUSH: begin
          if ((cnt == 5'd0) || (out_ready && (cnt <= 5'd8))) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_huff_packer.sv
// tb/tb_huff_packer.sv - scoreboard bench for huff_packer with a bit-queue reference model
module tb_huff_packer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       code_valid = 1'b0;
  logic [7:0] HC1 = 8'h00, HC2 = 8'h00, HC3 = 8'h00, HC4 = 8'h00, HC5 = 8'h00, HC6 = 8'h00;
  logic [7:0] M1 = 8'h00, M2 = 8'h00, M3 = 8'h00, M4 = 8'h00, M5 = 8'h00, M6 = 8'h00;
  logic       sym_valid = 1'b0;
  logic [7:0] sym_data = 8'h00;
  logic       sym_ready;
  logic       flush = 1'b0;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_last;
  logic       out_ready = 1'b0;
  logic       sym_err;

  huff_packer dut (
    .clk        (clk),
    .reset      (reset),
    .code_valid (code_valid),
    .HC1        (HC1),
    .HC2        (HC2),
    .HC3        (HC3),
    .HC4        (HC4),
    .HC5        (HC5),
    .HC6        (HC6),
    .M1         (M1),
    .M2         (M2),
    .M3         (M3),
    .M4         (M4),
    .M5         (M5),
    .M6         (M6),
    .sym_valid  (sym_valid),
    .sym_data   (sym_data),
    .sym_ready  (sym_ready),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_last   (out_last),
    .out_ready  (out_ready),
    .sym_err    (sym_err)
  );

  always #5 clk = ~clk;

  // Reference code table from the test plan: code value and bit length.
  int tcode [6] = '{0, 2, 6, 14, 30, 31};
  int tlen  [6] = '{1, 2, 3, 4, 5, 5};

  int n_cmp = 0;
  int n_bad = 0;
  int exp_err = 0;
  int obs_err = 0;
  int rdy_mode = 0;   // 0: always ready, 1: held low, 2: random

  bit         mbits [$];
  logic [8:0] exp_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic note_fail(input string name, input logic [31:0] info);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: info 0x%0h at %0t", name, info, $time);
  endtask

  // Model: every legal symbol appends its code bits; each 8 bits form a byte.
  function automatic void model_sym(input logic [7:0] s);
    int idx;
    logic [7:0] b;
    idx = int'(s) - 1;
    if (idx < 0 || idx > 5) begin
      exp_err++;
    end else begin
      for (int i = tlen[idx] - 1; i >= 0; i--) begin
        mbits.push_back(bit'((tcode[idx] >> i) & 1));
      end
      while (mbits.size() >= 8) begin
        b = 8'h00;
        for (int j = 0; j < 8; j++) b = {b[6:0], mbits.pop_front()};
        exp_q.push_back({1'b0, b});
      end
    end
  endfunction

  function automatic void model_flush();
    logic [7:0] b;
    int n;
    n = mbits.size();
    if (n > 0) begin
      b = 8'h00;
      for (int j = 0; j < 8; j++) b = {b[6:0], (j < n) ? mbits.pop_front() : 1'b0};
      exp_q.push_back({1'b1, b});
    end
  endfunction

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'b0;
      default: out_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  // Monitor: pops the scoreboard on every output handshake and checks that a
  // stalled byte stays put.
  logic       hold_v = 1'b0;
  logic [7:0] hold_d;
  logic       hold_l;
  logic [8:0] e;

  always @(negedge clk) begin
    if (!reset) begin
      hold_v = 1'b0;
    end else begin
      if (sym_err) obs_err++;
      if (hold_v) begin
        if (!out_valid) note_fail("valid_dropped", 32'(hold_d));
        else begin
          chk("hold_data", 32'(out_data), 32'(hold_d));
          chk("hold_last", 32'(out_last), 32'(hold_l));
        end
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) note_fail("unexpected_byte", 32'(out_data));
        else begin
          e = exp_q.pop_front();
          chk("byte_data", 32'(out_data), 32'(e[7:0]));
          chk("byte_last", 32'(out_last), 32'(e[8]));
        end
        hold_v = 1'b0;
      end else if (out_valid) begin
        hold_v = 1'b1;
        hold_d = out_data;
        hold_l = out_last;
      end else begin
        hold_v = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_table(input logic alt);
    if (!alt) begin
      HC1 = 8'h00; M1 = 8'h01; HC2 = 8'h02; M2 = 8'h03; HC3 = 8'h06; M3 = 8'h07;
      HC4 = 8'h0E; M4 = 8'h0F; HC5 = 8'h1E; M5 = 8'h1F; HC6 = 8'h1F; M6 = 8'h1F;
    end else begin
      HC1 = 8'h01; M1 = 8'h01; HC2 = 8'h01; M2 = 8'h01; HC3 = 8'h01; M3 = 8'h01;
      HC4 = 8'h01; M4 = 8'h01; HC5 = 8'h01; M5 = 8'h01; HC6 = 8'h01; M6 = 8'h01;
    end
    code_valid = 1'b1;
    step();
    code_valid = 1'b0;
  endtask

  task automatic send_sym(input logic [7:0] s);
    bit done;
    done = 1'b0;
    sym_valid = 1'b1;
    sym_data = s;
    for (int k = 0; k < 300 && !done; k++) begin
      @(negedge clk);
      if (sym_ready) begin
        model_sym(s);
        done = 1'b1;
      end
      step();
    end
    sym_valid = 1'b0;
    sym_data = 8'h00;
    if (!done) note_fail("send_timeout", 32'(s));
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int k = 0; k < 300 && !done; k++) begin
      @(negedge clk);
      if (!out_valid) done = 1'b1;
    end
    if (!done) note_fail("drain_timeout", 32'(out_data));
    step();
  endtask

  task automatic do_flush(input string name);
    bit done;
    drain();
    flush = 1'b1;
    model_flush();
    step();
    flush = 1'b0;
    done = 1'b0;
    for (int k = 0; k < 300 && !done; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !out_valid) done = 1'b1;
    end
    repeat (3) step();
    chk({name, "_pending"}, 32'(exp_q.size()), 32'h0);
    chk({name, "_out_valid"}, 32'(out_valid), 32'h0);
    chk({name, "_sym_err_count"}, 32'(obs_err), 32'(exp_err));
  endtask

  initial begin
    int nsym;
    bit seen;

    reset = 1'b0;
    repeat (3) step();
    chk("rst_sym_ready", 32'(sym_ready), 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_last", 32'(out_last), 32'h0);
    chk("rst_sym_err", 32'(sym_err), 32'h0);
    chk("rst_out_data", 32'(out_data), 32'h0);
    reset = 1'b1;
    step();

    // flush in IDLE is ignored: nothing becomes ready or valid
    flush = 1'b1;
    step();
    flush = 1'b0;
    repeat (2) step();
    chk("idle_flush_ready", 32'(sym_ready), 32'h0);

    // Basic stream 1,2,3,4 -> 0x5B, 0x80 last
    rdy_mode = 0;
    load_table(1'b0);
    chk("load_sym_ready", 32'(sym_ready), 32'h1);
    send_sym(8'd1); send_sym(8'd2); send_sym(8'd3); send_sym(8'd4);
    do_flush("t1");
    chk("t1_idle_ready", 32'(sym_ready), 32'h0);

    // Eight symbol-1 codes form one full byte, flush adds nothing
    load_table(1'b0);
    for (int i = 0; i < 8; i++) send_sym(8'd1);
    do_flush("t2");

    // Backpressure: two 6s fill 10 bits, byte held while out_ready low
    load_table(1'b0);
    rdy_mode = 1;
    repeat (2) step();
    send_sym(8'd6); send_sym(8'd6);
    chk("bp_sym_ready", 32'(sym_ready), 32'h0);
    chk("bp_out_valid", 32'(out_valid), 32'h1);
    chk("bp_out_data", 32'(out_data), 32'hFF);
    repeat (10) step();
    chk("bp_out_data_held", 32'(out_data), 32'hFF);
    rdy_mode = 0;
    send_sym(8'd6); send_sym(8'd6);
    do_flush("t3");

    // Illegal symbols are consumed without bits
    load_table(1'b0);
    send_sym(8'd2); send_sym(8'd0); send_sym(8'd7); send_sym(8'd2);
    do_flush("t4");

    // Table reload during RUN is ignored
    load_table(1'b0);
    load_table(1'b1);
    send_sym(8'd3); send_sym(8'd1); send_sym(8'd5); send_sym(8'd2);
    do_flush("t5");

    // Reset with 5 buffered bits discards them
    load_table(1'b0);
    send_sym(8'd2); send_sym(8'd3);
    chk("mid_out_valid", 32'(out_valid), 32'h0);
    reset = 1'b0;
    step();
    mbits.delete();
    chk("mid_rst_out_valid", 32'(out_valid), 32'h0);
    chk("mid_rst_out_data", 32'(out_data), 32'h0);
    chk("mid_rst_sym_ready", 32'(sym_ready), 32'h0);
    chk("mid_rst_out_last", 32'(out_last), 32'h0);
    reset = 1'b1;
    sym_valid = 1'b1;
    sym_data = 8'd1;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (sym_ready || out_valid) seen = 1'b1;
      step();
    end
    sym_valid = 1'b0;
    chk("post_rst_no_accept", 32'(seen), 32'h0);

    // Randomized streams with random backpressure and illegal symbols
    for (int r = 0; r < 8; r++) begin
      rdy_mode = (r == 0) ? 0 : 2;
      load_table(1'b0);
      nsym = $urandom_range(5, 40);
      for (int i = 0; i < nsym; i++) begin
        if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) step();
        if ($urandom_range(0, 5) == 0) send_sym(($urandom_range(0, 1) == 0) ? 8'd0 : 8'(7 + $urandom_range(0, 248)));
        else send_sym(8'($urandom_range(1, 6)));
      end
      do_flush("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
